board_stream_gen: RTL and testbench



---
 rtl/board_stream_gen.sv | 252 +++++++++++++++++++++++++
 tb/tb_board_stream_gen.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/board_stream_gen.sv
// Reversi board picture as an AXI4-Stream video source: one {R,B,G} pixel per beat,
// TUSER on frame start, TLAST on line end, board inputs snapshotted once per frame.
module board_stream_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CELL     = 48,
  parameter int ORIGIN_X = 128,
  parameter int ORIGIN_Y = 48,
  parameter int RADIUS   = 20
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        enable,
  input  logic [63:0] board_black,
  input  logic [63:0] board_white,
  input  logic [5:0]  cursor,
  output logic [23:0] M_AXIS_TDATA,
  output logic        M_AXIS_TUSER,
  output logic        M_AXIS_TLAST,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam int OW = 6;

  localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);
  localparam logic [XW-1:0] X_ONE   = XW'(1);
  localparam logic [YW-1:0] Y_ONE   = YW'(1);
  localparam logic [XW:0]   X_LO    = (XW+1)'(ORIGIN_X);
  localparam logic [XW:0]   X_HI    = (XW+1)'(ORIGIN_X + 8 * CELL);
  localparam logic [YW:0]   Y_LO    = (YW+1)'(ORIGIN_Y);
  localparam logic [YW:0]   Y_HI    = (YW+1)'(ORIGIN_Y + 8 * CELL);
  localparam logic [OW-1:0] O_ZERO  = OW'(0);
  localparam logic [OW-1:0] O_ONE   = OW'(1);
  localparam logic [OW-1:0] O_TWO   = OW'(2);
  localparam logic [OW-1:0] O_RING2 = OW'(CELL - 2);
  localparam logic [OW-1:0] O_LAST  = OW'(CELL - 1);
  localparam logic [OW-1:0] O_HALF  = OW'(CELL / 2);
  localparam logic [12:0]   R_SQ    = 13'(RADIUS * RADIUS);

  localparam logic [23:0] C_GREY  = 24'h202020;
  localparam logic [23:0] C_GRID  = 24'h000000;
  localparam logic [23:0] C_RED   = 24'hFF0000;
  localparam logic [23:0] C_BLACK = 24'h000000;
  localparam logic [23:0] C_WHITE = 24'hFFFFFF;
  localparam logic [23:0] C_GREEN = 24'h000080;

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t        state_r, state_nx;
  logic          done_r;
  logic [XW-1:0] x_r, x_nx;
  logic [YW-1:0] y_r, y_nx;
  logic [OW-1:0] ox_r, ox_nx, oy_r, oy_nx;
  logic [2:0]    col_r, col_nx, row_r, row_nx;
  logic [63:0]   snap_black_r, snap_white_r;
  logic [5:0]    snap_cursor_r;
  logic          latch_s, load_s, drop_s, last_px_s;
  logic          in_board_s, disc_s;
  logic [5:0]    cell_s;
  logic [OW-1:0] mag_x_s, mag_y_s;
  logic [11:0]   sq_x_s, sq_y_s;
  logic [12:0]   dist_s;
  logic [23:0]   pix_s;
  logic [23:0]   tdata_r;
  logic          tuser_r, tlast_r, tvalid_r;

  function automatic logic on_ring(input logic [OW-1:0] o);
    return (o == O_ONE) || (o == O_TWO) || (o == O_RING2) || (o == O_LAST);
  endfunction

  assign last_px_s = (x_r == X_LAST) && (y_r == Y_LAST);

  // Frame sequencing: snapshot at frame start, drop TVALID only after the final beat is taken
  always_comb begin
    state_nx = state_r;
    latch_s  = 1'b0;
    load_s   = 1'b0;
    drop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable) begin
          latch_s  = 1'b1;
          state_nx = ACTIVE;
        end else begin
          state_nx = IDLE;
        end
      end
      ACTIVE: begin
        if (!tvalid_r || M_AXIS_TREADY) begin
          if (done_r) begin
            drop_s   = 1'b1;
            state_nx = IDLE;
          end else begin
            load_s   = 1'b1;
            latch_s  = last_px_s && enable;
            state_nx = ACTIVE;
          end
        end else begin
          state_nx = ACTIVE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Next raster position; cell column/row and in-cell offsets step incrementally instead of dividing
  always_comb begin
    x_nx   = x_r;
    y_nx   = y_r;
    ox_nx  = ox_r;
    oy_nx  = oy_r;
    col_nx = col_r;
    row_nx = row_r;
    if (x_r == X_LAST) begin
      x_nx   = {XW{1'b0}};
      ox_nx  = O_ZERO;
      col_nx = 3'd0;
      if (y_r == Y_LAST) begin
        y_nx = {YW{1'b0}};
      end else begin
        y_nx = y_r + Y_ONE;
      end
      if ({1'b0, y_nx} <= Y_LO) begin
        oy_nx  = O_ZERO;
        row_nx = 3'd0;
      end else if (oy_r == O_LAST) begin
        oy_nx  = O_ZERO;
        row_nx = row_r + 3'd1;
      end else begin
        oy_nx  = oy_r + O_ONE;
        row_nx = row_r;
      end
    end else begin
      x_nx = x_r + X_ONE;
      if ({1'b0, x_nx} <= X_LO) begin
        ox_nx  = O_ZERO;
        col_nx = 3'd0;
      end else if (ox_r == O_LAST) begin
        ox_nx  = O_ZERO;
        col_nx = col_r + 3'd1;
      end else begin
        ox_nx  = ox_r + O_ONE;
        col_nx = col_r;
      end
    end
  end

  assign in_board_s = ({1'b0, x_r} >= X_LO) && ({1'b0, x_r} <= X_HI) &&
                      ({1'b0, y_r} >= Y_LO) && ({1'b0, y_r} <= Y_HI);
  assign cell_s     = {row_r, col_r};
  assign mag_x_s    = (ox_r >= O_HALF) ? (ox_r - O_HALF) : (O_HALF - ox_r);
  assign mag_y_s    = (oy_r >= O_HALF) ? (oy_r - O_HALF) : (O_HALF - oy_r);
  assign sq_x_s     = {6'd0, mag_x_s} * {6'd0, mag_x_s};
  assign sq_y_s     = {6'd0, mag_y_s} * {6'd0, mag_y_s};
  assign dist_s     = {1'b0, sq_x_s} + {1'b0, sq_y_s};
  assign disc_s     = dist_s < R_SQ;

  // Pixel colour by priority: surround, grid, cursor ring, disc, felt
  always_comb begin
    pix_s = C_GREY;
    if (!in_board_s) begin
      pix_s = C_GREY;
    end else if ((ox_r == O_ZERO) || (oy_r == O_ZERO)) begin
      pix_s = C_GRID;
    end else if ((cell_s == snap_cursor_r) && (on_ring(ox_r) || on_ring(oy_r))) begin
      pix_s = C_RED;
    end else if (disc_s && snap_black_r[cell_s]) begin
      pix_s = C_BLACK;
    end else if (disc_s && snap_white_r[cell_s]) begin
      pix_s = C_WHITE;
    end else begin
      pix_s = C_GREEN;
    end
  end

  // State register
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Snapshot and raster counters
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      snap_black_r  <= 64'd0;
      snap_white_r  <= 64'd0;
      snap_cursor_r <= 6'd0;
      x_r           <= {XW{1'b0}};
      y_r           <= {YW{1'b0}};
      ox_r          <= O_ZERO;
      oy_r          <= O_ZERO;
      col_r         <= 3'd0;
      row_r         <= 3'd0;
      done_r        <= 1'b0;
    end else begin
      if (latch_s) begin
        snap_black_r  <= board_black;
        snap_white_r  <= board_white;
        snap_cursor_r <= cursor;
      end
      if (state_r == IDLE) begin
        x_r    <= {XW{1'b0}};
        y_r    <= {YW{1'b0}};
        ox_r   <= O_ZERO;
        oy_r   <= O_ZERO;
        col_r  <= 3'd0;
        row_r  <= 3'd0;
        done_r <= 1'b0;
      end else if (load_s) begin
        x_r    <= x_nx;
        y_r    <= y_nx;
        ox_r   <= ox_nx;
        oy_r   <= oy_nx;
        col_r  <= col_nx;
        row_r  <= row_nx;
        done_r <= last_px_s && !enable;
      end else if (drop_s) begin
        done_r <= 1'b0;
      end
    end
  end

  // Stream output register; holds while stalled
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      tdata_r  <= 24'd0;
      tuser_r  <= 1'b0;
      tlast_r  <= 1'b0;
      tvalid_r <= 1'b0;
    end else if (load_s) begin
      tdata_r  <= pix_s;
      tuser_r  <= (x_r == {XW{1'b0}}) && (y_r == {YW{1'b0}});
      tlast_r  <= (x_r == X_LAST);
      tvalid_r <= 1'b1;
    end else if (drop_s) begin
      tvalid_r <= 1'b0;
    end
  end

  assign M_AXIS_TDATA  = tdata_r;
  assign M_AXIS_TUSER  = tuser_r;
  assign M_AXIS_TLAST  = tlast_r;
  assign M_AXIS_TVALID = tvalid_r;

endmodule

// File: tb/tb_board_stream_gen.sv
// Self-checking bench for board_stream_gen on a reduced raster; every accepted beat is
// compared with a reference picture computed directly from the drawing rules.
module tb_board_stream_gen;

  localparam int H   = 96;
  localparam int V   = 88;
  localparam int CL  = 10;
  localparam int OXP = 6;
  localparam int OYP = 4;
  localparam int RAD = 4;
  localparam int FR  = H * V;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        enable;
  logic [63:0] board_black, board_white;
  logic [5:0]  cursor;
  logic [23:0] tdata;
  logic        tuser, tlast, tvalid, tready;

  int errors = 0;
  int checks = 0;
  int pos    = 0;

  logic [63:0] a_blk, a_wht, b_blk, b_wht, c_blk, c_wht, d_blk, d_wht;
  logic [5:0]  a_cur, b_cur, c_cur, d_cur;

  board_stream_gen #(
    .H_ACTIVE(H), .V_ACTIVE(V), .CELL(CL),
    .ORIGIN_X(OXP), .ORIGIN_Y(OYP), .RADIUS(RAD)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable),
    .board_black(board_black), .board_white(board_white), .cursor(cursor),
    .M_AXIS_TDATA(tdata), .M_AXIS_TUSER(tuser), .M_AXIS_TLAST(tlast),
    .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready)
  );

  always #5 ACLK = ~ACLK;

  // Reference beat {tuser, tlast, pixel} straight from the picture rules
  function automatic logic [25:0] exp_beat(input int x, input int y, input logic [63:0] b,
                                           input logic [63:0] w, input logic [5:0] c);
    int dx, dy, col, row, ox, oy, idx, d2;
    logic [23:0] pix;
    bit ring;
    dx = x - OXP;
    dy = y - OYP;
    if (dx < 0 || dx > 8 * CL || dy < 0 || dy > 8 * CL) begin
      pix = 24'h202020;
    end else begin
      col  = dx / CL;
      row  = dy / CL;
      ox   = dx % CL;
      oy   = dy % CL;
      idx  = row * 8 + col;
      ring = (ox == 1 || ox == 2 || ox == CL - 2 || ox == CL - 1 ||
              oy == 1 || oy == 2 || oy == CL - 2 || oy == CL - 1);
      d2   = (ox - CL / 2) * (ox - CL / 2) + (oy - CL / 2) * (oy - CL / 2);
      if (ox == 0 || oy == 0)                 pix = 24'h000000;
      else if (idx == int'(c) && ring)        pix = 24'hFF0000;
      else if (d2 < RAD * RAD && b[idx])      pix = 24'h000000;
      else if (d2 < RAD * RAD && w[idx])      pix = 24'hFFFFFF;
      else                                    pix = 24'h000080;
    end
    return {(x == 0 && y == 0), (x == H - 1), pix};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s at pos %0d: observed %h expected %h", tag, pos, obs, expv);
    end
  endtask

  // Consume nbeats handshakes (TREADY always 1 or 50% random), checking order, content and stall hold
  task automatic stream(input int nbeats, input bit rnd, input logic [63:0] b,
                        input logic [63:0] w, input logic [5:0] c);
    int got = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [26:0] held = 27'd0;
    while (got < nbeats && cyc < nbeats * 16 + 200) begin
      @(negedge ACLK);
      cyc++;
      if (stalled) check("stall_hold", {5'd0, tvalid, tuser, tlast, tdata}, {5'd0, held});
      tready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (tvalid && tready) begin
        check("beat", {6'd0, tuser, tlast, tdata}, {6'd0, exp_beat(pos % H, pos / H, b, w, c)});
        pos     = (pos + 1) % FR;
        got++;
        stalled = 1'b0;
      end else begin
        stalled = tvalid;
        held    = {tvalid, tuser, tlast, tdata};
      end
    end
    check("beat_budget", got, nbeats);
  endtask

  initial begin
    a_blk = {$urandom(), $urandom()} | 64'h1;
    a_wht = {$urandom(), $urandom()} & ~a_blk;
    a_cur = 6'd9;
    b_blk = {$urandom(), $urandom()} & ~64'h1;
    b_wht = ({$urandom(), $urandom()} | 64'h1) & ~b_blk;
    b_cur = 6'd0;
    c_blk = {$urandom(), $urandom()} & ~64'h1;
    c_wht = {$urandom(), $urandom()} & ~c_blk & ~64'h1;
    c_cur = 6'($urandom_range(0, 63));
    d_blk = {$urandom(), $urandom()};
    d_wht = {$urandom(), $urandom()};
    d_cur = 6'($urandom_range(0, 63));

    ARESETN     = 1'b0;
    enable      = 1'b0;
    tready      = 1'b0;
    board_black = 64'd0;
    board_white = 64'd0;
    cursor      = 6'd0;
    repeat (3) @(negedge ACLK);
    check("reset_outputs", {5'd0, tvalid, tuser, tlast, tdata}, 32'd0);
    ARESETN = 1'b1;
    repeat (3) @(negedge ACLK);
    check("idle_no_valid", {31'd0, tvalid}, 32'd0);

    board_black = a_blk;
    board_white = a_wht;
    cursor      = a_cur;
    enable      = 1'b1;
    @(negedge ACLK);
    check("start_valid_low", {31'd0, tvalid}, 32'd0);
    @(negedge ACLK);
    check("first_beat", {5'd0, tvalid, tuser, tlast, tdata},
          {5'd0, 1'b1, exp_beat(0, 0, a_blk, a_wht, a_cur)});

    pos = 0;
    stream(FR / 2, 1'b0, a_blk, a_wht, a_cur);
    board_black = b_blk;
    board_white = b_wht;
    cursor      = b_cur;
    stream(FR - FR / 2, 1'b0, a_blk, a_wht, a_cur);

    stream(FR / 2, 1'b1, b_blk, b_wht, b_cur);
    board_black = c_blk;
    board_white = c_wht;
    cursor      = c_cur;
    stream(FR - FR / 2, 1'b1, b_blk, b_wht, b_cur);

    stream(FR / 2, 1'b1, c_blk, c_wht, c_cur);
    enable = 1'b0;
    stream(FR - FR / 2, 1'b1, c_blk, c_wht, c_cur);
    @(posedge ACLK);
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      check("post_frame_idle", {31'd0, tvalid}, 32'd0);
    end

    board_black = d_blk;
    board_white = d_wht;
    cursor      = d_cur;
    enable      = 1'b1;
    pos         = 0;
    stream(1000, 1'b0, d_blk, d_wht, d_cur);
    ARESETN = 1'b0;
    @(negedge ACLK);
    check("midframe_reset", {5'd0, tvalid, tuser, tlast, tdata}, 32'd0);
    ARESETN = 1'b1;
    pos     = 0;
    stream(3 * H, 1'b1, d_blk, d_wht, d_cur);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
